// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Clears x1..x31 after reset, then grants one of two writeback requesters
// per cycle. Requester B has priority unless A has waited long enough.
// Accepted writes appear on a single registered write port one cycle later.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        we,
  output logic [4:0]  rd,
  output logic [31:0] wd,
  output logic        init_done
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t     LP_RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [3:0] LP_LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [4:0] LP_LAST_REG  = 5'd31;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_clr_cnt;
  logic [3:0]  r_wait_cnt;
  logic        r_we;
  logic [4:0]  r_rd;
  logic [31:0] r_wd;
  logic        r_init_done;

  logic        w_a_ready;
  logic        w_b_ready;
  logic        w_a_starved;
  logic        w_xfer;
  logic [4:0]  w_sel_rd;
  logic [31:0] w_sel_data;

  // State register; reset picks CLEAR or RUN depending on CLEAR_ON_RESET.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LP_RST_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic, grant decision and selection of the winning write.
  always_comb begin
    w_state_nxt = r_state;
    w_a_ready   = 1'b0;
    w_b_ready   = 1'b0;
    w_a_starved = (r_wait_cnt >= LP_LIMIT);
    w_xfer      = 1'b0;
    w_sel_rd    = '0;
    w_sel_data  = '0;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_cnt == LP_LAST_REG) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!rst) begin
          w_a_ready = a_valid && (!b_valid || w_a_starved);
          w_b_ready = b_valid && !w_a_ready;
        end
      end
      default: w_state_nxt = LP_RST_STATE;
    endcase
    w_xfer = w_a_ready || w_b_ready;
    if (w_a_ready) begin
      w_sel_rd   = a_rd;
      w_sel_data = a_data;
    end else if (w_b_ready) begin
      w_sel_rd   = b_rd;
      w_sel_data = b_data;
    end
  end

  // Clear counter walks x1..x31 and stops at 31 rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_cnt <= 5'd1;
    end else if (r_state == ST_CLEAR && r_clr_cnt != LP_LAST_REG) begin
      r_clr_cnt <= r_clr_cnt + 5'd1;
    end
  end

  // Starvation counter: counts RUN cycles where A waits, saturating at 15.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (!a_valid || w_a_ready) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_RUN && r_wait_cnt != 4'hF) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // Registered write port: clear writes, granted writes, or an idle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we <= 1'b0;
      r_rd <= '0;
      r_wd <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_we <= 1'b1;
      r_rd <= r_clr_cnt;
      r_wd <= '0;
    end else if (w_xfer) begin
      // x0 is hardwired: the transfer is accepted but never written.
      r_we <= (w_sel_rd != 5'd0);
      r_rd <= w_sel_rd;
      r_wd <= w_sel_data;
    end else begin
      r_we <= 1'b0;
    end
  end

  // init_done mirrors the RUN state one register stage deep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_done <= (LP_RST_STATE == ST_RUN);
    end else begin
      r_init_done <= (w_state_nxt == ST_RUN);
    end
  end

  assign a_ready   = w_a_ready;
  assign b_ready   = w_b_ready;
  assign we        = r_we;
  assign rd        = r_rd;
  assign wd        = r_wd;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: clear sequence, arbitration table with a
// scoreboard of expected write-port values, reset corner cases, and the
// CLEAR_ON_RESET=0 variant.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, we, init_done;
  logic [4:0]  rd;
  logic [31:0] wd;

  logic        rst0;
  logic        a0_valid, b0_valid;
  logic [4:0]  a0_rd, b0_rd;
  logic [31:0] a0_data, b0_data;
  logic        a0_ready, b0_ready, we0, init_done0;
  logic [4:0]  rd0;
  logic [31:0] wd0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.STARVE_LIMIT(4), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .we(we), .rd(rd), .wd(wd), .init_done(init_done)
  );

  regfile_write_arbiter #(.STARVE_LIMIT(4), .CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .rst(rst0),
    .a_valid(a0_valid), .a_rd(a0_rd), .a_data(a0_data), .a_ready(a0_ready),
    .b_valid(b0_valid), .b_rd(b0_rd), .b_data(b0_data), .b_ready(b0_ready),
    .we(we0), .rd(rd0), .wd(wd0), .init_done(init_done0)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bdata;
    logic        ea;
    logic        eb;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    bit          chk_data;
  } exp_t;

  vec_t        tbl[14];
  exp_t        sbq[$];
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                              input logic bv, input logic [4:0] brd, input logic [31:0] bdata,
                              input logic ea, input logic eb);
    vec_t v;
    v.av = av; v.ard = ard; v.adata = adata;
    v.bv = bv; v.brd = brd; v.bdata = bdata;
    v.ea = ea; v.eb = eb;
    return v;
  endfunction

  // Expects to be entered at posedge+1; leaves at the next posedge+1.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    a_valid = v.av; a_rd = v.ard; a_data = v.adata;
    b_valid = v.bv; b_rd = v.brd; b_data = v.bdata;
    #2;
    chk($sformatf("v%0d_a_ready", idx), 32'(a_ready), 32'(v.ea));
    chk($sformatf("v%0d_b_ready", idx), 32'(b_ready), 32'(v.eb));
    if (v.ea || v.eb) begin
      e.rd       = v.ea ? v.ard : v.brd;
      e.wd       = v.ea ? v.adata : v.bdata;
      e.we       = (e.rd != 5'd0);
      e.chk_data = e.we;
      if (e.we) begin
        m_rd = e.rd;
        m_wd = e.wd;
      end
    end else begin
      e.we = 1'b0; e.rd = m_rd; e.wd = m_wd; e.chk_data = 1'b1;
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      chk($sformatf("v%0d_sb_empty", idx), 32'd1, 32'd0);
    end else begin
      got = sbq.pop_front();
      chk($sformatf("v%0d_we", idx), 32'(we), 32'(got.we));
      if (got.chk_data) begin
        chk($sformatf("v%0d_rd", idx), 32'(rd), 32'(got.rd));
        chk($sformatf("v%0d_wd", idx), wd, got.wd);
      end
    end
  endtask

  // Observes n clear writes; expects to be entered at posedge+1.
  task automatic clear_seq(input int unsigned n);
    for (int unsigned k = 1; k <= n; k++) begin
      #2;
      chk($sformatf("clr%0d_a_ready", k), 32'(a_ready), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("clr%0d_we", k), 32'(we), 32'd1);
      chk($sformatf("clr%0d_rd", k), 32'(rd), k);
      chk($sformatf("clr%0d_wd", k), wd, 32'd0);
      chk($sformatf("clr%0d_init_done", k), 32'(init_done), 32'(k == 31));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h11;
    b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h22;
    rst0 = 1'b1; a0_valid = 1'b0; a0_rd = '0; a0_data = '0;
    b0_valid = 1'b0; b0_rd = '0; b0_data = '0;
    m_rd = '0; m_wd = '0;

    tbl[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 32'h0,    1, 0);
    tbl[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    0, 0);
    tbl[2]  = mk(0, 5'd0,  32'h0,        1, 5'd0, 32'h1234, 0, 1);
    tbl[3]  = mk(0, 5'd0,  32'h0,        1, 5'd7, 32'h77,   0, 1);
    tbl[4]  = mk(1, 5'd9,  32'hA0000009, 1, 5'd3, 32'hB0,   0, 1);
    tbl[5]  = mk(1, 5'd9,  32'hA0000009, 1, 5'd3, 32'hB1,   0, 1);
    tbl[6]  = mk(1, 5'd9,  32'hA0000009, 1, 5'd3, 32'hB2,   0, 1);
    tbl[7]  = mk(1, 5'd9,  32'hA0000009, 1, 5'd3, 32'hB3,   0, 1);
    tbl[8]  = mk(1, 5'd9,  32'hA0000009, 1, 5'd3, 32'hB4,   1, 0);
    tbl[9]  = mk(0, 5'd0,  32'h0,        1, 5'd3, 32'hB4,   0, 1);
    tbl[10] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    0, 0);
    tbl[11] = mk(1, 5'd12, 32'hC00C,     1, 5'd3, 32'hD0,   0, 1);
    tbl[12] = mk(1, 5'd12, 32'hC00C,     0, 5'd0, 32'h0,    1, 0);
    tbl[13] = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    0, 0);

    // Reset with both requesters valid: no grants, write port cleared.
    @(posedge clk); #1;
    #2;
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst0_a_ready", 32'(a0_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_wd", wd, 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst0_init_done", 32'(init_done0), 32'd1);

    // Release both; dut0 skips the clear and accepts immediately.
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    rst0 = 1'b0; a0_valid = 1'b1; a0_rd = 5'd4; a0_data = 32'h44;
    #2;
    chk("noclr_a_ready", 32'(a0_ready), 32'd1);
    chk("noclr_b_ready", 32'(b0_ready), 32'd0);
    @(posedge clk); #1;
    a0_valid = 1'b0;
    chk("noclr_we", 32'(we0), 32'd1);
    chk("noclr_rd", 32'(rd0), 32'd4);
    chk("noclr_wd", wd0, 32'h44);
    chk("noclr_init_done", 32'(init_done0), 32'd1);
    chk("clr1_we", 32'(we), 32'd1);
    chk("clr1_rd", 32'(rd), 32'd1);
    chk("clr1_init_done", 32'(init_done), 32'd0);
    @(posedge clk); #1;
    chk("noclr_idle_we", 32'(we0), 32'd0);
    chk("clr2_rd", 32'(rd), 32'd2);

    // Remaining clear writes x3..x31.
    for (int unsigned k = 3; k <= 31; k++) begin
      @(posedge clk); #1;
      chk($sformatf("clr%0d_we", k), 32'(we), 32'd1);
      chk($sformatf("clr%0d_rd", k), 32'(rd), k);
      chk($sformatf("clr%0d_wd", k), wd, 32'd0);
      chk($sformatf("clr%0d_init_done", k), 32'(init_done), 32'(k == 31));
    end
    m_rd = 5'd31; m_wd = 32'd0;

    // Arbitration table, starting in the first RUN cycle.
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i], i);
    end

    // Reset pulse at the tenth clear edge restarts the clear from x1.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("r2_init_done", 32'(init_done), 32'd0);
    clear_seq(9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("e10_we", 32'(we), 32'd0);
    chk("e10_rd", 32'(rd), 32'd0);
    chk("e10_init_done", 32'(init_done), 32'd0);
    clear_seq(31);

    // Reset during a pending transfer drops it.
    a_valid = 1'b1; a_rd = 5'd6; a_data = 32'h66; rst = 1'b1;
    #2;
    chk("xrst_a_ready", 32'(a_ready), 32'd0);
    @(posedge clk); #1;
    chk("xrst_we", 32'(we), 32'd0);
    chk("xrst_init_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    #2;
    chk("xrst_clear_a_ready", 32'(a_ready), 32'd0);
    @(posedge clk); #1;
    a_valid = 1'b0;
    chk("xrst_clr1_rd", 32'(rd), 32'd1);
    chk("xrst_clr1_we", 32'(we), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive stalled cycles after which requester A overrides B's priority (range 1..15).
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero x1..x31 after reset, 0 = skip the clear.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-005 SHALL have ports a_valid in 1, a_rd in 5, a_data in 32: requester A, execute writeback.
REQ-006 SHALL have port a_ready  out  1: A transfer accepted this cycle.
REQ-007 SHALL have ports b_valid in 1, b_rd in 5, b_data in 32: requester B, load writeback.
REQ-008 SHALL have port b_ready  out  1: B transfer accepted this cycle.
REQ-009 SHALL have ports we out 1, rd out 5, wd out 32: registered write port to the register file.
REQ-010 SHALL have port init_done  out  1: high once the clear sequence completes (state RUN).

Function
REQ-011 SHALL implement a two-state FSM, CLEAR and RUN; reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-012 In CLEAR, SHALL load the output register each cycle with we=1, rd=clr_cnt, wd=0; clr_cnt starts at 1 and increments by 1.
REQ-013 SHALL move CLEAR->RUN on the edge that loads rd=31; clr_cnt SHALL never issue 0 and SHALL never wrap.
REQ-014 SHALL hold a_ready=b_ready=0 while in CLEAR or while rst=1; both combinational from state, valids and wait_cnt.
REQ-015 A transfer occurs in cycle N when x_valid && x_ready; requesters hold x_valid, x_rd, x_data stable until accepted.
REQ-016 In RUN, at most one ready SHALL be high per cycle; a ready SHALL never be high without its valid.
REQ-017 Priority: B wins when both are valid, unless wait_cnt >= STARVE_LIMIT, in which case A wins.
REQ-018 A lone valid requester SHALL be accepted in the same cycle (ready=1) in RUN.
REQ-019 wait_cnt (4 bits) SHALL increment, saturating at 15, on each RUN cycle with a_valid && !a_ready; SHALL clear on A acceptance, on a_valid=0, and on reset.
REQ-020 A transfer accepted in cycle N SHALL appear as we=1, rd=x_rd, wd=x_data for exactly cycle N+1; latency 1, throughput 1 write/cycle.
REQ-021 A transfer with x_rd=0 SHALL be accepted (ready=1) but SHALL produce we=0 in cycle N+1.
REQ-022 In cycles with no transfer, we SHALL be 0 in the following cycle; rd and wd then hold their previous values.
REQ-023 The output register SHALL never backpressure; no internal buffering beyond the single output stage.
REQ-024 init_done SHALL equal (state==RUN) and SHALL be registered.

Reset
REQ-025 rst=1 at an edge SHALL set we=0, rd=0, wd=0, wait_cnt=0, clr_cnt=1, and state per REQ-011; init_done=0 if CLEAR_ON_RESET=1, else 1.
REQ-026 rst asserted mid-CLEAR or mid-transfer SHALL abort it; the transfer accepted in the reset cycle is dropped, and the clear restarts from x1.
REQ-027 Taking E1 as the first rising edge with rst=0 (CLEAR_ON_RESET=1): edges E1..E31 load rd=1..31, init_done=1 after E31, and first acceptance is possible in the cycle after E31.

Verification
REQ-028 Reset release, no requests -> we high for 31 consecutive cycles with rd 1..31 ascending and wd=0, then init_done=1 and we=0.
REQ-029 RUN, only a_valid, a_rd=5, a_data=0xDEADBEEF -> a_ready same cycle; next cycle we=1, rd=5, wd=0xDEADBEEF; then we=0.
REQ-030 RUN, both valid continuously (B: rd=3, new data each cycle), STARVE_LIMIT=4 -> B granted 4 cycles, A granted on the 5th, then wait_cnt=0.
REQ-031 RUN, b_valid with b_rd=0, b_data=0x1234 -> b_ready=1, and the next cycle we=0.
REQ-032 rst pulsed for 1 cycle at E10 of CLEAR -> no we in the following cycle, clear restarts at rd=1, init_done stays 0 until 31 further writes.
REQ-033 CLEAR_ON_RESET=0 -> init_done=1 immediately after reset, and a request in the first post-reset cycle is accepted.
